nios2_debug_slave_cmd_sync: RTL and testbench
=============================================

// Module: nios2_debug_slave_cmd_sync
// PURPOSE
//  System-clock side of the Nios II JTAG debug slave, generalised from the fixed 2-bit IR / 38-bit DR version.
//  Synchronises virtual-JTAG update strobes (vs_udr, vs_uir) from the TCK domain and captures the
//  quasi-static shift register (sr) and instruction (ir_in) on each DR update.
//  Presents one held valid/ready command per IR code to the OCI consumers (break, ocimem, tracectrl),
//  replacing single-cycle take_action pulses. Adds sticky overrun reporting for dropped updates.
// PARAMETERS
//  DR_WIDTH     38  width of sr / jdo data register
//  IR_WIDTH     2   width of ir_in; command channels NCH = 2**IR_WIDTH
//  SYNC_STAGES  2   flops per synchroniser chain (legal >= 2)
// PORTS
//  clk          in   1            system clock; only clock
//  reset        in   1            asynchronous, active-high reset
//  vs_udr       in   1            virtual update-DR level, TCK domain (asynchronous)
//  vs_uir       in   1            virtual update-IR level, TCK domain (asynchronous)
//  ir_in        in   IR_WIDTH     current virtual IR; stable while vs_udr high
//  sr           in   DR_WIDTH     TCK-domain shift register; stable while vs_udr high
//  jdo          out  DR_WIDTH     captured DR contents of the last accepted update
//  ir_latched   out  IR_WIDTH     IR code of the last accepted update
//  cmd_valid    out  NCH          bit i: command for IR code i pending
//  cmd_ready    in   NCH          bit i: consumer i accepts this cycle
//  ir_update    out  1            one-cycle pulse per synchronised vs_uir rising edge
//  cmd_overrun  out  NCH          sticky: update for IR code i dropped
//  overrun_clr  in   1            clears all cmd_overrun bits
// BEHAVIOUR
//  Reset (async, active-high): jdo=0, ir_latched=0, cmd_valid=0, cmd_overrun=0, ir_update=0;
//    synchroniser chains, edge-delay flops and arm counter all cleared.
//  Arming: after reset deasserts, a counter runs SYNC_STAGES+1 cycles; udr_rise/uir_rise are masked
//    until it saturates, so a strobe already high at reset release never produces a command.
//  Sync: vs_udr, vs_uir each pass SYNC_STAGES flops, then a delay flop; rise = last & ~delay & armed.
//  Latency: vs_udr first sampled high at edge k -> udr_rise during cycle after edge k+SYNC_STAGES-1;
//    jdo / ir_latched / cmd_valid update at edge k+SYNC_STAGES (SYNC_STAGES+1 edges total).
//  Capture on udr_rise, with busy = |(cmd_valid & ~cmd_ready):
//    busy=0 -> jdo<=sr, ir_latched<=ir_in, cmd_valid[ir_in]<=1 (exactly one bit set).
//    busy=1 -> jdo, ir_latched, cmd_valid held; cmd_overrun[ir_in]<=1.
//  Handshake: cmd_valid[i] stays high, with jdo stable, until an edge where cmd_valid[i]&cmd_ready[i];
//    it clears on that edge. cmd_ready with cmd_valid low is ignored. An accept and a new capture
//    on the same edge: capture wins for its channel (handshake completes, new command pending).
//  ir_update: registered one-cycle pulse on uir_rise; also clears every pending cmd_valid
//    (host changed IR -> pending command aborted, no overrun). Same-cycle udr_rise: clear first,
//    then capture proceeds as busy=0.
//  cmd_overrun: set bits win over same-cycle overrun_clr; otherwise overrun_clr zeroes all bits.
//  Consecutive udr_rise are >= 2 clk apart by construction (edge detect of a level); no FIFO.
//  No arithmetic beyond arm counter ($clog2(SYNC_STAGES+2) bits, saturating, no wrap).
// TESTING
//  1. Reset, hold vs_udr=1 through reset release -> no cmd_valid for 10 cycles, cmd_overrun=0.
//  2. SYNC_STAGES=2: ir_in=2'b01, sr=38'h2A_DEAD_BEEF, vs_udr 0->1 -> cmd_valid=4'b0010 after
//     3 edges, jdo=38'h2A_DEAD_BEEF, ir_latched=1; ready[1] high 1 cycle -> cmd_valid=0.
//  3. Pending ch1 not accepted, second update ir_in=2'b11, sr=38'h1 -> jdo unchanged,
//     cmd_overrun=4'b1000; overrun_clr pulse -> cmd_overrun=0.
//  4. Pending ch0, vs_uir pulse -> ir_update one cycle, cmd_valid=0, cmd_overrun=0.
//  5. ready[2] accepted on same edge as new ir_in=2'b10 capture -> cmd_valid[2] stays 1, jdo=new sr.
//  6. Assert reset with cmd_valid=4'b0100, cmd_overrun=4'b0001 -> all outputs 0 immediately,
//     before next clk edge.

Source files
------------

// File: rtl/nios2_debug_slave_cmd_sync.sv
// System-clock side of the Nios II JTAG debug slave: synchronises virtual-JTAG update strobes,
// captures the DR/IR on each update and presents one held valid/ready command per IR code.
module nios2_debug_slave_cmd_sync #(
  parameter int unsigned DR_WIDTH    = 38,
  parameter int unsigned IR_WIDTH    = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      vs_udr,
  input  logic                      vs_uir,
  input  logic [IR_WIDTH-1:0]       ir_in,
  input  logic [DR_WIDTH-1:0]       sr,
  output logic [DR_WIDTH-1:0]       jdo,
  output logic [IR_WIDTH-1:0]       ir_latched,
  output logic [(2**IR_WIDTH)-1:0]  cmd_valid,
  input  logic [(2**IR_WIDTH)-1:0]  cmd_ready,
  output logic                      ir_update,
  output logic [(2**IR_WIDTH)-1:0]  cmd_overrun,
  input  logic                      overrun_clr
);

  localparam int unsigned Nch    = 2 ** IR_WIDTH;
  localparam int unsigned ArmMax = SYNC_STAGES + 1;
  localparam int unsigned CntW   = $clog2(SYNC_STAGES + 2);

  logic [SYNC_STAGES-1:0] udr_sync_q, uir_sync_q;
  logic                   udr_dly_q, uir_dly_q;
  logic [CntW-1:0]        arm_q, arm_d;
  logic                   armed;
  logic                   udr_rise, uir_rise;

  logic [DR_WIDTH-1:0]    jdo_q, jdo_d;
  logic [IR_WIDTH-1:0]    ir_q, ir_d;
  logic [Nch-1:0]         valid_q, valid_d;
  logic [Nch-1:0]         ovr_q, ovr_d;
  logic                   ir_update_q;
  logic                   busy;

  assign armed    = (arm_q == CntW'(ArmMax));
  assign arm_d    = armed ? arm_q : arm_q + CntW'(1);
  assign udr_rise = udr_sync_q[SYNC_STAGES-1] & ~udr_dly_q & armed;
  assign uir_rise = uir_sync_q[SYNC_STAGES-1] & ~uir_dly_q & armed;

  // Delay flops track the synchronised level even while unarmed, so a strobe
  // already high at reset release is seen as steady rather than as an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      udr_sync_q <= '0;
      uir_sync_q <= '0;
      udr_dly_q  <= 1'b0;
      uir_dly_q  <= 1'b0;
      arm_q      <= '0;
    end else begin
      udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
      uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
      udr_dly_q  <= udr_sync_q[SYNC_STAGES-1];
      uir_dly_q  <= uir_sync_q[SYNC_STAGES-1];
      arm_q      <= arm_d;
    end
  end

  always_comb begin
    jdo_d   = jdo_q;
    ir_d    = ir_q;
    valid_d = valid_q & ~cmd_ready;
    ovr_d   = overrun_clr ? '0 : ovr_q;
    busy    = |(valid_q & ~cmd_ready);
    // An IR change aborts whatever is pending, so a same-cycle update is never busy.
    if (uir_rise) begin
      valid_d = '0;
      busy    = 1'b0;
    end
    if (udr_rise) begin
      if (!busy) begin
        jdo_d          = sr;
        ir_d           = ir_in;
        valid_d[ir_in] = 1'b1;
      end else begin
        ovr_d[ir_in] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jdo_q       <= '0;
      ir_q        <= '0;
      valid_q     <= '0;
      ovr_q       <= '0;
      ir_update_q <= 1'b0;
    end else begin
      jdo_q       <= jdo_d;
      ir_q        <= ir_d;
      valid_q     <= valid_d;
      ovr_q       <= ovr_d;
      ir_update_q <= uir_rise;
    end
  end

  assign jdo         = jdo_q;
  assign ir_latched  = ir_q;
  assign cmd_valid   = valid_q;
  assign cmd_overrun = ovr_q;
  assign ir_update   = ir_update_q;

endmodule

// File: tb/tb_nios2_debug_slave_cmd_sync.sv
// Directed bench for nios2_debug_slave_cmd_sync: expected commands are queued by the stimulus and
// checked by a monitor at every valid/ready handshake.
module tb_nios2_debug_slave_cmd_sync;

  logic        clk = 1'b0;
  logic        reset;
  logic        vs_udr, vs_uir;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic [37:0] jdo;
  logic [1:0]  ir_latched;
  logic [3:0]  cmd_valid, cmd_ready, cmd_overrun;
  logic        ir_update, overrun_clr;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]  ch;
    logic [37:0] data;
  } exp_t;

  exp_t sb_q[$];

  nios2_debug_slave_cmd_sync #(
    .DR_WIDTH   (38),
    .IR_WIDTH   (2),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .vs_udr     (vs_udr),
    .vs_uir     (vs_uir),
    .ir_in      (ir_in),
    .sr         (sr),
    .jdo        (jdo),
    .ir_latched (ir_latched),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .ir_update  (ir_update),
    .cmd_overrun(cmd_overrun),
    .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise vs_udr with new ir/sr, wait the 3-edge capture latency, then drop it and let it settle.
  task automatic do_update(input logic [1:0] ir, input logic [37:0] data);
    ir_in  = ir;
    sr     = data;
    vs_udr = 1'b1;
    repeat (3) tick();
    vs_udr = 1'b0;
  endtask

  task automatic settle();
    repeat (4) tick();
  endtask

  task automatic accept(input logic [1:0] ch);
    cmd_ready     = '0;
    cmd_ready[ch] = 1'b1;
    tick();
    cmd_ready = '0;
  endtask

  // Monitor: every handshake visible before the next edge consumes one expected command.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && (cmd_valid & cmd_ready) != 4'b0000) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_handshake: got valid&ready=%b expected none", cmd_valid & cmd_ready);
        end else begin
          e = sb_q.pop_front();
          chk("hs_channel", 64'(cmd_valid & cmd_ready), 64'(4'b0001 << e.ch));
          chk("hs_jdo", 64'(jdo), 64'(e.data));
          chk("hs_ir_latched", 64'(ir_latched), 64'(e.ch));
        end
      end
    end
  end

  initial begin
    reset       = 1'b1;
    vs_udr      = 1'b1;
    vs_uir      = 1'b0;
    ir_in       = 2'd0;
    sr          = '0;
    cmd_ready   = '0;
    overrun_clr = 1'b0;

    // 1: strobe held high through reset release must not produce a command
    repeat (3) tick();
    chk("reset_jdo", 64'(jdo), 64'd0);
    chk("reset_valid", 64'(cmd_valid), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("armed_no_cmd", 64'(cmd_valid), 64'd0);
    end
    chk("armed_no_overrun", 64'(cmd_overrun), 64'd0);
    vs_udr = 1'b0;
    settle();

    // 2: basic capture and accept
    sb_q.push_back('{ch: 2'd1, data: 38'h2A_DEAD_BEEF});
    do_update(2'd1, 38'h2A_DEAD_BEEF);
    chk("t2_valid", 64'(cmd_valid), 64'b0010);
    chk("t2_jdo", 64'(jdo), 64'h2A_DEAD_BEEF);
    chk("t2_ir", 64'(ir_latched), 64'd1);
    settle();
    chk("t2_held", 64'(cmd_valid), 64'b0010);
    accept(2'd1);
    chk("t2_cleared", 64'(cmd_valid), 64'd0);

    // 3: overrun while ch1 pending
    sb_q.push_back('{ch: 2'd1, data: 38'h11_1111_1111});
    do_update(2'd1, 38'h11_1111_1111);
    settle();
    do_update(2'd3, 38'h1);
    chk("t3_jdo_held", 64'(jdo), 64'h11_1111_1111);
    chk("t3_valid_held", 64'(cmd_valid), 64'b0010);
    chk("t3_overrun", 64'(cmd_overrun), 64'b1000);
    settle();
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("t3_overrun_clr", 64'(cmd_overrun), 64'd0);
    accept(2'd1);
    chk("t3_cleared", 64'(cmd_valid), 64'd0);

    // 4: IR update aborts a pending command
    do_update(2'd0, 38'h3F_0000_0001);
    settle();
    chk("t4_pending", 64'(cmd_valid), 64'b0001);
    vs_uir = 1'b1;
    repeat (3) tick();
    chk("t4_ir_update", 64'(ir_update), 64'd1);
    chk("t4_aborted", 64'(cmd_valid), 64'd0);
    chk("t4_no_overrun", 64'(cmd_overrun), 64'd0);
    tick();
    chk("t4_pulse_end", 64'(ir_update), 64'd0);
    vs_uir = 1'b0;
    settle();

    // 5: accept and new capture on the same edge
    sb_q.push_back('{ch: 2'd2, data: 38'h00_AAAA_5555});
    do_update(2'd2, 38'h00_AAAA_5555);
    settle();
    sb_q.push_back('{ch: 2'd2, data: 38'h15_1234_5678});
    ir_in  = 2'd2;
    sr     = 38'h15_1234_5678;
    vs_udr = 1'b1;
    repeat (2) tick();
    cmd_ready[2] = 1'b1;
    tick();
    cmd_ready = '0;
    vs_udr    = 1'b0;
    chk("t5_valid", 64'(cmd_valid), 64'b0100);
    chk("t5_jdo", 64'(jdo), 64'h15_1234_5678);
    chk("t5_no_overrun", 64'(cmd_overrun), 64'd0);
    settle();
    accept(2'd2);
    chk("t5_cleared", 64'(cmd_valid), 64'd0);

    // 6: asynchronous reset clears everything before the next edge
    do_update(2'd2, 38'h0F_FFFF_0000);
    settle();
    do_update(2'd0, 38'h01_0203_0405);
    settle();
    chk("t6_valid", 64'(cmd_valid), 64'b0100);
    chk("t6_overrun", 64'(cmd_overrun), 64'b0001);
    #3;
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(cmd_valid), 64'd0);
    chk("t6_rst_overrun", 64'(cmd_overrun), 64'd0);
    chk("t6_rst_jdo", 64'(jdo), 64'd0);
    chk("t6_rst_ir", 64'(ir_latched), 64'd0);
    chk("t6_rst_ir_update", 64'(ir_update), 64'd0);
    tick();
    reset = 1'b0;
    tick();

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
